// File: rtl/flag_unit_pkg.sv
// Shared definitions for the NZCV flag unit: flag bit positions,
// multiply-tracker state encoding and the default multiplier latency.
package flag_unit_pkg;

    // Bit positions of the flags inside a 4-bit {N,Z,C,V} vector
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    // Default multiply latency and the counter width that covers 2..7
    localparam int MUL_LAT_DEFAULT = 3;
    localparam int CNT_W           = 3;

    typedef enum logic {
        MUL_IDLE    = 1'b0,
        MUL_PENDING = 1'b1
    } mulState_t;

endpackage

// File: rtl/flag_mul_tracker.sv
// Tracks one in-flight flag-setting multiply: the IDLE/PENDING state, the
// latency down-counter and whether a younger EX flag write has made the
// multiply's result stale.
module flag_mul_tracker
    import flag_unit_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mulStart,     // accepted issue (already qualified by flush)
    input  logic mulAbort,     // cancel the pending multiply
    input  logic exWrite,      // younger EX instruction writes flags this cycle
    output logic mulPending,   // tracker is in PENDING
    output logic mulCommit,    // multiply result is the flag value this cycle
    output logic holdWindow    // a flag consumer must wait this cycle
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mulState_t        stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic             supQ, supD;
    logic             completion;

    // The completion cycle is the last PENDING cycle (counter reached 1)
    assign completion = (stateQ == MUL_PENDING) && (cntQ == CNT_ONE);

    // State register: FSM state, latency counter and superseded bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= MUL_IDLE;
            cntQ   <= '0;
            supQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            supQ   <= supD;
        end
    end

    // Next-state logic; a start while PENDING is ignored, abort beats completion
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        supD   = supQ;
        case (stateQ)
            MUL_IDLE: begin
                if (mulStart) begin
                    stateD = MUL_PENDING;
                    cntD   = LOAD_VAL;
                    supD   = 1'b0;
                end
            end
            MUL_PENDING: begin
                if (mulAbort || completion) begin
                    stateD = MUL_IDLE;
                    cntD   = '0;
                    supD   = 1'b0;
                end else begin
                    if (cntQ > CNT_ONE) begin
                        cntD = cntQ - CNT_ONE;
                    end
                    if (exWrite) begin
                        supD = 1'b1;
                    end
                end
            end
            default: begin
                stateD = MUL_IDLE;
                cntD   = '0;
                supD   = 1'b0;
            end
        endcase
    end

    // Outputs: the result only lands if nothing younger wrote flags first
    always_comb begin
        mulPending = (stateQ == MUL_PENDING);
        mulCommit  = completion && !mulAbort && !supQ && !exWrite;
        holdWindow = mulPending && !completion && !supQ && !exWrite && !mulAbort;
    end

endmodule

// File: rtl/flag_unit.sv
// NZCV flag unit: architectural flag register with a combinational bypass
// from the EX stage and from a multi-cycle flag-setting multiply, plus the
// stall that holds a conditional branch until its flags are known.
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ex_valid,
    input  logic       ex_set_flags,
    input  logic       ex_flush,
    input  logic [3:0] ex_nzcv,
    input  logic       mul_start,
    input  logic       mul_abort,
    input  logic [3:0] mul_nzcv,
    input  logic       id_uses_flags,
    output logic       negative,
    output logic       zero,
    output logic       carry_out,
    output logic       overflow,
    output logic       flag_stall,
    output logic       mul_pending
);

    logic [3:0] nzcvQ;
    logic [3:0] flagsBypass;
    logic       exWrite;
    logic       mulStartOk;
    logic       mulCommit;
    logic       holdWindow;
    logic       trackerPending;

    // A squashed EX instruction neither writes flags nor issues a multiply
    assign exWrite    = ex_valid && ex_set_flags && !ex_flush;
    assign mulStartOk = mul_start && !ex_flush;

    flag_mul_tracker #(
        .MUL_LAT(MUL_LAT)
    ) uTracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .mulStart  (mulStartOk),
        .mulAbort  (mul_abort),
        .exWrite   (exWrite),
        .mulPending(trackerPending),
        .mulCommit (mulCommit),
        .holdWindow(holdWindow)
    );

    // Architectural flags: EX is younger than the multiply, so it wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcvQ <= 4'b0000;
        end else if (exWrite) begin
            nzcvQ <= ex_nzcv;
        end else if (mulCommit) begin
            nzcvQ <= mul_nzcv;
        end
    end

    // Bypass mux: forward this cycle's writer; force zeros while in reset
    always_comb begin
        flagsBypass = nzcvQ;
        if (exWrite) begin
            flagsBypass = ex_nzcv;
        end else if (mulCommit) begin
            flagsBypass = mul_nzcv;
        end
        if (!rst_n) begin
            flagsBypass = 4'b0000;
        end
    end

    assign negative    = flagsBypass[NZCV_N];
    assign zero        = flagsBypass[NZCV_Z];
    assign carry_out   = flagsBypass[NZCV_C];
    assign overflow    = flagsBypass[NZCV_V];
    assign flag_stall  = rst_n && id_uses_flags && holdWindow;
    assign mul_pending = trackerPending;

endmodule

// File: tb/tb_flag_unit.sv
// Bench for flag_unit: directed scenarios followed by random traffic, all
// checked against a cycle-numbered reference model of the flag rules.
module tb_flag_unit;

    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       rstN;
    logic       exValid, exSetFlags, exFlush;
    logic [3:0] exNzcv;
    logic       mulStart, mulAbort;
    logic [3:0] mulNzcv;
    logic       idUses;
    logic       negative, zero, carryOut, overflow, flagStall, mulPendingO;

    int total = 0;
    int bad   = 0;

    // Reference model: committed flags, whether a multiply is in flight,
    // the cycle it was issued, and whether a younger write overtook it.
    logic [3:0] mArch;
    bit         mBusy;
    bit         mSup;
    int         mIssue;
    int         cyc = 0;

    // Last observed outputs, for constant checks in the directed steps
    logic [3:0] lastFlags;
    logic       lastStall;
    logic       lastPend;

    flag_unit #(.MUL_LAT(LAT)) dut (
        .clk          (clk),
        .rst_n        (rstN),
        .ex_valid     (exValid),
        .ex_set_flags (exSetFlags),
        .ex_flush     (exFlush),
        .ex_nzcv      (exNzcv),
        .mul_start    (mulStart),
        .mul_abort    (mulAbort),
        .mul_nzcv     (mulNzcv),
        .id_uses_flags(idUses),
        .negative     (negative),
        .zero         (zero),
        .carry_out    (carryOut),
        .overflow     (overflow),
        .flag_stall   (flagStall),
        .mul_pending  (mulPendingO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input bit sf, input bit fl, input logic [3:0] nz,
                         input bit ms, input bit ma, input logic [3:0] mn, input bit id);
        exValid    = v;
        exSetFlags = sf;
        exFlush    = fl;
        exNzcv     = nz;
        mulStart   = ms;
        mulAbort   = ma;
        mulNzcv    = mn;
        idUses     = id;
    endtask

    task automatic idle();
        drive(0, 0, 0, 4'h0, 0, 0, 4'h0, 0);
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then advance it
    task automatic step(input string tag);
        bit         exW, compl, commit;
        logic [3:0] eFlags;
        logic       eStall, ePend;
        @(negedge clk);
        exW    = exValid && exSetFlags && !exFlush;
        compl  = mBusy && (cyc == mIssue + LAT - 1);
        commit = compl && !mulAbort && !mSup && !exW;
        if (!rstN) begin
            eFlags = 4'b0000;
            eStall = 1'b0;
            ePend  = 1'b0;
        end else begin
            eFlags = exW ? exNzcv : (commit ? mulNzcv : mArch);
            eStall = idUses && mBusy && !compl && !mSup && !exW && !mulAbort;
            ePend  = mBusy;
        end
        lastFlags = {negative, zero, carryOut, overflow};
        lastStall = flagStall;
        lastPend  = mulPendingO;
        chk({tag, "_flags"}, {4'h0, lastFlags}, {4'h0, eFlags});
        chk({tag, "_stall"}, {7'h0, lastStall}, {7'h0, eStall});
        chk({tag, "_pend"},  {7'h0, lastPend},  {7'h0, ePend});
        @(posedge clk);
        if (!rstN) begin
            mArch = 4'b0000;
            mBusy = 0;
            mSup  = 0;
        end else begin
            if (exW) mArch = exNzcv;
            else if (commit) mArch = mulNzcv;
            if (mBusy) begin
                if (mulAbort || compl) begin
                    mBusy = 0;
                    mSup  = 0;
                end else if (exW) begin
                    mSup = 1;
                end
            end else if (mulStart && !exFlush) begin
                mBusy  = 1;
                mSup   = 0;
                mIssue = cyc;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        mArch = 4'b0000;
        mBusy = 0;
        mSup  = 0;
        mIssue = 0;
        rstN = 1'b0;
        // Reset with an EX write presented: outputs must still read zero
        drive(1, 1, 0, 4'hF, 0, 0, 4'hF, 1);
        step("rst");
        chk("rst_flags_const", {4'h0, lastFlags}, 8'h00);
        step("rst2");
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        cyc++;
        #1;

        // EX write forwards same cycle, lands next cycle
        drive(1, 1, 0, 4'b1000, 0, 0, 4'h0, 0);
        step("ex_w");
        chk("ex_w_neg", {7'h0, lastFlags[3]}, 8'h01);
        idle();
        step("ex_after");
        chk("ex_after_q", {4'h0, lastFlags}, 8'h08);

        // Flushed EX write is invisible
        drive(1, 1, 1, 4'b0111, 0, 0, 4'h0, 0);
        step("ex_flush");
        chk("ex_flush_q", {4'h0, lastFlags}, 8'h08);

        // Multiply: stall one cycle, forward result on completion
        drive(0, 0, 0, 4'h0, 1, 0, 4'h0, 1);
        step("mul_iss");
        drive(0, 0, 0, 4'h0, 0, 0, 4'h0, 1);
        step("mul_c1");
        chk("mul_c1_stall", {7'h0, lastStall}, 8'h01);
        drive(0, 0, 0, 4'h0, 0, 0, 4'b0100, 1);
        step("mul_c2");
        chk("mul_c2_fwd", {3'h0, lastStall, lastFlags}, 8'h04);
        idle();
        step("mul_after");
        chk("mul_after_q", {3'h0, lastPend, lastFlags}, 8'h04);

        // Younger EX write supersedes the multiply result
        drive(0, 0, 0, 4'h0, 1, 0, 4'h0, 1);
        step("sup_iss");
        drive(1, 1, 0, 4'b0010, 0, 0, 4'h0, 1);
        step("sup_c1");
        chk("sup_c1_stall", {7'h0, lastStall}, 8'h00);
        drive(0, 0, 0, 4'h0, 0, 0, 4'b1001, 1);
        step("sup_c2");
        chk("sup_c2_flags", {3'h0, lastStall, lastFlags}, 8'h02);
        idle();
        step("sup_after");
        chk("sup_after_q", {4'h0, lastFlags}, 8'h02);

        // Abort in the first PENDING cycle drops stall at once, no write
        drive(0, 0, 0, 4'h0, 1, 0, 4'h0, 1);
        step("ab_iss");
        drive(0, 0, 0, 4'h0, 0, 1, 4'hF, 1);
        step("ab_c1");
        chk("ab_c1_stall", {7'h0, lastStall}, 8'h00);
        drive(0, 0, 0, 4'h0, 0, 0, 4'hF, 1);
        step("ab_c2");
        chk("ab_c2_state", {3'h0, lastPend, lastFlags}, 8'h02);

        // Multiply issue squashed by flush stays IDLE
        drive(0, 0, 1, 4'h0, 1, 0, 4'h0, 1);
        step("fl_iss");
        drive(0, 0, 0, 4'h0, 0, 0, 4'hA, 1);
        step("fl_c1");
        chk("fl_c1_pend", {7'h0, lastPend}, 8'h00);

        // Reset in the middle of PENDING with flags 1111
        drive(1, 1, 0, 4'b1111, 0, 0, 4'h0, 0);
        step("rp_set");
        drive(0, 0, 0, 4'h0, 1, 0, 4'h0, 1);
        step("rp_iss");
        idle();
        rstN = 1'b0;
        #1;
        chk("rp_async", {2'h0, flagStall, mulPendingO, negative, zero, carryOut, overflow}, 8'h00);
        drive(0, 0, 0, 4'h0, 0, 0, 4'b1111, 1);
        step("rp_hold");
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        step("rp_r1");
        step("rp_r2");
        chk("rp_nowrite", {3'h0, lastPend, lastFlags}, 8'h00);

        // Random traffic; never issue a second multiply while one is pending
        for (int i = 0; i < 400; i++) begin
            bit ms, ma;
            ms = (!mBusy) && ($urandom_range(0, 3) == 0);
            ma = mBusy && ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 5) == 0, 4'($urandom), ms, ma,
                  4'($urandom), $urandom_range(0, 1) == 1);
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
